aurora_hls_nfc_ctrl: RTL and testbench

AURORA_HLS_NFC_CTRL -- requirements
Module: aurora_hls_nfc_ctrl

---
 rtl/aurora_hls_nfc_ctrl.sv | 167 ++++++++++++++++
 tb/tb_aurora_hls_nfc_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_hls_nfc_ctrl.sv
// rtl/aurora_hls_nfc_ctrl.sv - Aurora native flow control (XOFF/XON) requester driven by RX FIFO fill level
//
// Watches the RX FIFO occupancy and asks the link partner to stop (XOFF, 16'hFFFF)
// when it climbs to FULL_THRESH, and to resume (XON, 16'h0000) once it drains to
// EMPTY_THRESH. While the partner is held off, XOFF is re-sent every
// REFRESH_CYCLES cycles so a lost request cannot leave the partner running.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               synchronous active-low reset
//   counter_reset       synchronous clear of the statistics counters only
//   nfc_enable          flow control enable; low suppresses new XOFF and releases a pause
//   fifo_rx_fill_level  current RX FIFO occupancy
//   rx_tvalid           RX data beat valid (counted while paused)
//   s_axi_nfc_tready    NFC sink ready
//   s_axi_nfc_tvalid    NFC request valid
//   s_axi_nfc_tdata     NFC word, bit 0 is the MSB
//   paused              high while the link partner is being held off
//   xoff_count          first XOFF handshakes from RUN
//   xon_count           XON handshakes
//   refresh_count       refresh XOFF handshakes
//   paused_beat_count   RX beats seen while paused
module aurora_hls_nfc_ctrl #(
    parameter int FILL_WIDTH     = 10,
    parameter int FULL_THRESH    = 768,
    parameter int EMPTY_THRESH   = 256,
    parameter int REFRESH_CYCLES = 4096,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   counter_reset,
    input  logic                   nfc_enable,
    input  logic [FILL_WIDTH-1:0]  fifo_rx_fill_level,
    input  logic                   rx_tvalid,
    input  logic                   s_axi_nfc_tready,
    output logic                   s_axi_nfc_tvalid,
    output logic [0:15]            s_axi_nfc_tdata,
    output logic                   paused,
    output logic [COUNT_WIDTH-1:0] xoff_count,
    output logic [COUNT_WIDTH-1:0] xon_count,
    output logic [COUNT_WIDTH-1:0] refresh_count,
    output logic [COUNT_WIDTH-1:0] paused_beat_count
);

    localparam logic [FILL_WIDTH-1:0]  FULL_LVL  = FILL_WIDTH'(FULL_THRESH);
    localparam logic [FILL_WIDTH-1:0]  EMPTY_LVL = FILL_WIDTH'(EMPTY_THRESH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    // The timer only has to hold 0 .. REFRESH_CYCLES-1.
    localparam int               TW           = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit               REFRESH_EN   = (REFRESH_CYCLES > 0);
    localparam logic [TW-1:0]    REFRESH_LAST = TW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    localparam logic [0:15] XOFF_WORD = 16'hFFFF;
    localparam logic [0:15] XON_WORD  = 16'h0000;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_RUN,
        ST_SEND_XOFF,
        ST_PAUSED,
        ST_SEND_XON
    } state_t;

    state_t          state;
    logic            refresh_xoff;   // the XOFF in flight is a refresh, not the first one
    logic [TW-1:0]   refresh_timer;

    logic above_full;
    logic below_empty;

    assign above_full  = (fifo_rx_fill_level >= FULL_LVL);
    assign below_empty = (fifo_rx_fill_level <= EMPTY_LVL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_RESET;
            s_axi_nfc_tvalid <= 1'b0;
            s_axi_nfc_tdata  <= XON_WORD;
            paused           <= 1'b0;
            refresh_xoff     <= 1'b0;
            refresh_timer    <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (nfc_enable && above_full) begin
                        state            <= ST_SEND_XOFF;
                        s_axi_nfc_tvalid <= 1'b1;
                        s_axi_nfc_tdata  <= XOFF_WORD;
                        paused           <= 1'b1;
                        refresh_xoff     <= 1'b0;
                    end
                end
                ST_SEND_XOFF: begin
                    // tvalid is held high here, so tready alone completes the handshake.
                    if (s_axi_nfc_tready) begin
                        state            <= ST_PAUSED;
                        s_axi_nfc_tvalid <= 1'b0;
                        refresh_timer    <= '0;
                    end
                end
                ST_PAUSED: begin
                    // Releasing the partner wins over a refresh due in the same cycle.
                    if (below_empty || !nfc_enable) begin
                        state            <= ST_SEND_XON;
                        s_axi_nfc_tvalid <= 1'b1;
                        s_axi_nfc_tdata  <= XON_WORD;
                    end else if (REFRESH_EN && (refresh_timer == REFRESH_LAST)) begin
                        state            <= ST_SEND_XOFF;
                        s_axi_nfc_tvalid <= 1'b1;
                        s_axi_nfc_tdata  <= XOFF_WORD;
                        refresh_xoff     <= 1'b1;
                    end else begin
                        refresh_timer <= refresh_timer + 1'b1;
                    end
                end
                ST_SEND_XON: begin
                    if (s_axi_nfc_tready) begin
                        state            <= ST_RUN;
                        s_axi_nfc_tvalid <= 1'b0;
                        paused           <= 1'b0;
                    end
                end
                default: begin
                    state            <= ST_RESET;
                    s_axi_nfc_tvalid <= 1'b0;
                    paused           <= 1'b0;
                end
            endcase
        end
    end

    logic xoff_hs;
    logic refresh_hs;
    logic xon_hs;
    logic beat_hit;

    assign xoff_hs    = (state == ST_SEND_XOFF) && s_axi_nfc_tready && !refresh_xoff;
    assign refresh_hs = (state == ST_SEND_XOFF) && s_axi_nfc_tready &&  refresh_xoff;
    assign xon_hs     = (state == ST_SEND_XON)  && s_axi_nfc_tready;
    assign beat_hit   = rx_tvalid && paused;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] cnt,
                                                       input logic                   hit);
        return (hit && (cnt != COUNT_MAX)) ? cnt + 1'b1 : cnt;
    endfunction

    // counter_reset takes precedence over any increment landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || counter_reset) begin
            xoff_count        <= '0;
            xon_count         <= '0;
            refresh_count     <= '0;
            paused_beat_count <= '0;
        end else begin
            xoff_count        <= sat_inc(xoff_count, xoff_hs);
            xon_count         <= sat_inc(xon_count, xon_hs);
            refresh_count     <= sat_inc(refresh_count, refresh_hs);
            paused_beat_count <= sat_inc(paused_beat_count, beat_hit);
        end
    end

endmodule

// File: tb/tb_aurora_hls_nfc_ctrl.sv
// tb/tb_aurora_hls_nfc_ctrl.sv - scoreboard bench for aurora_hls_nfc_ctrl against a behavioural flow-control model
module tb_aurora_hls_nfc_ctrl;

    localparam int FILL_WIDTH = 10;
    localparam int FULL       = 768;
    localparam int EMPTY      = 256;
    localparam int REFRESH    = 16;
    localparam int CW         = 6;
    localparam int CMAX       = (1 << CW) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  counter_reset = 1'b0;
    logic                  nfc_enable = 1'b1;
    logic [FILL_WIDTH-1:0] fill_level = '0;
    logic                  rx_tvalid = 1'b0;
    logic                  tready = 1'b1;
    logic                  tvalid;
    logic [0:15]           tdata;
    logic                  paused;
    logic [CW-1:0]         xoff_count;
    logic [CW-1:0]         xon_count;
    logic [CW-1:0]         refresh_count;
    logic [CW-1:0]         paused_beat_count;

    aurora_hls_nfc_ctrl #(
        .FILL_WIDTH    (FILL_WIDTH),
        .FULL_THRESH   (FULL),
        .EMPTY_THRESH  (EMPTY),
        .REFRESH_CYCLES(REFRESH),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .counter_reset     (counter_reset),
        .nfc_enable        (nfc_enable),
        .fifo_rx_fill_level(fill_level),
        .rx_tvalid         (rx_tvalid),
        .s_axi_nfc_tready  (tready),
        .s_axi_nfc_tvalid  (tvalid),
        .s_axi_nfc_tdata   (tdata),
        .paused            (paused),
        .xoff_count        (xoff_count),
        .xon_count         (xon_count),
        .refresh_count     (refresh_count),
        .paused_beat_count (paused_beat_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    bit mon_en = 1'b0;

    // Behavioural model: whether the partner is held off, the request word
    // waiting for the sink (-1 when none), and how long the current pause lasted.
    int m_in_reset = 1;
    int m_hold     = 0;
    int m_word     = -1;
    int m_is_ref   = 0;
    int m_wait     = 0;
    int m_xoff = 0, m_xon = 0, m_refc = 0, m_beat = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic issue(input int word, input int is_ref);
        m_word   = word;
        m_is_ref = is_ref;
        exp_q.push_back(word);
    endtask

    // Applies the rules to the inputs that were present at the edge just taken.
    task automatic model_step();
        if (!rst_n) begin
            if (m_word >= 0) void'(exp_q.pop_back());
            m_in_reset = 1; m_hold = 0; m_word = -1; m_wait = 0;
            m_xoff = 0; m_xon = 0; m_refc = 0; m_beat = 0;
            return;
        end
        if (rx_tvalid && m_hold != 0) m_beat = sat(m_beat + 1);
        if (m_in_reset != 0) begin
            m_in_reset = 0;
        end else if (m_word >= 0) begin
            if (tready) begin
                if (m_word == 16'hFFFF) begin
                    if (m_is_ref != 0) m_refc = sat(m_refc + 1);
                    else               m_xoff = sat(m_xoff + 1);
                    m_wait = 0;
                end else begin
                    m_xon  = sat(m_xon + 1);
                    m_hold = 0;
                end
                m_word = -1;
            end
        end else if (m_hold == 0) begin
            if (nfc_enable && int'(fill_level) >= FULL) begin
                issue(16'hFFFF, 0);
                m_hold = 1;
            end
        end else if (int'(fill_level) <= EMPTY || !nfc_enable) begin
            issue(16'h0000, 0);
        end else begin
            m_wait++;
            if (m_wait == REFRESH) issue(16'hFFFF, 1);
        end
        if (counter_reset) begin
            m_xoff = 0; m_xon = 0; m_refc = 0; m_beat = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("tvalid", int'(tvalid), (m_word >= 0) ? 1 : 0);
            if (m_word >= 0) chk("tdata", int'(tdata), m_word);
            chk("paused", int'(paused), m_hold);
            chk("xoff_count", int'(xoff_count), m_xoff);
            chk("xon_count", int'(xon_count), m_xon);
            chk("refresh_count", int'(refresh_count), m_refc);
            chk("paused_beat_count", int'(paused_beat_count), m_beat);
            if (rst_n && tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("handshake_expected", 1, 0);
                end else begin
                    chk("handshake_word", int'(tdata), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) cycle();
        chk("rst_tvalid", int'(tvalid), 0);
        chk("rst_tdata", int'(tdata), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_counters", int'(xoff_count) + int'(xon_count) + int'(refresh_count) + int'(paused_beat_count), 0);

        rst_n = 1'b1; fill_level = 0; tready = 1'b1;
        repeat (3) cycle();
        chk("idle_paused", int'(paused), 0);

        // First XOFF: request visible one cycle after the sample
        fill_level = 768;
        cycle();
        chk("xoff_tvalid", int'(tvalid), 1);
        chk("xoff_tdata", int'(tdata), 16'hFFFF);
        chk("xoff_paused", int'(paused), 1);
        cycle();
        chk("xoff_count_1", int'(xoff_count), 1);

        // Hysteresis band then XON at the low threshold
        fill_level = 500;
        repeat (5) cycle();
        chk("band_no_nfc", int'(tvalid), 0);
        chk("band_paused", int'(paused), 1);
        fill_level = 256;
        cycle();
        chk("xon_tvalid", int'(tvalid), 1);
        chk("xon_tdata", int'(tdata), 0);
        cycle();
        chk("xon_count_1", int'(xon_count), 1);
        chk("xon_paused", int'(paused), 0);

        // Refresh: 16 paused cycles plus one handshake cycle per period
        fill_level = 800;
        repeat (2 + 3 * 17 - 1) cycle();
        chk("refresh_count_2", int'(refresh_count), 2);
        cycle();
        chk("refresh_count_3", int'(refresh_count), 3);
        chk("xoff_count_2", int'(xoff_count), 2);

        // Back-pressured XOFF stays stable
        fill_level = 200;
        repeat (2) cycle();
        tready = 1'b0; fill_level = 800;
        cycle();
        for (int i = 0; i < 5; i++) begin
            chk("stall_tvalid", int'(tvalid), 1);
            chk("stall_tdata", int'(tdata), 16'hFFFF);
            if (i < 4) cycle();
        end
        tready = 1'b1;
        cycle();
        chk("stall_xoff_count", int'(xoff_count), 3);
        chk("stall_tvalid_low", int'(tvalid), 0);

        // counter_reset on the XON handshake cycle
        fill_level = 100; tready = 1'b0;
        cycle();
        tready = 1'b1; counter_reset = 1'b1;
        cycle();
        counter_reset = 1'b0;
        chk("clr_counters", int'(xoff_count) + int'(xon_count) + int'(refresh_count) + int'(paused_beat_count), 0);
        chk("clr_run", int'(paused), 0);

        // Reset in the middle of a stalled XOFF
        fill_level = 900; tready = 1'b0;
        cycle();
        chk("abort_pre_tvalid", int'(tvalid), 1);
        rst_n = 1'b0;
        cycle();
        chk("abort_tvalid", int'(tvalid), 0);
        chk("abort_xoff_count", int'(xoff_count), 0);
        rst_n = 1'b1; tready = 1'b1;
        cycle();
        chk("rerun_tvalid_low", int'(tvalid), 0);
        cycle();
        chk("reissue_tvalid", int'(tvalid), 1);
        chk("reissue_tdata", int'(tdata), 16'hFFFF);
        cycle();
        chk("reissue_xoff_count", int'(xoff_count), 1);

        // Saturation of the beat counter during a long pause
        rx_tvalid = 1'b1;
        repeat (80) cycle();
        chk("beat_saturated", int'(paused_beat_count), CMAX);
        rx_tvalid = 1'b0;

        // Disable releases the pause and suppresses new XOFF
        nfc_enable = 1'b0;
        repeat (4) cycle();
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("disabled_no_xoff", int'(tvalid), 0);
        end
        nfc_enable = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: fill_level = FILL_WIDTH'($urandom_range(0, 1023));
                    1: fill_level = FILL_WIDTH'($urandom_range(FULL - 2, FULL + 2));
                    2: fill_level = FILL_WIDTH'($urandom_range(EMPTY - 2, EMPTY + 2));
                    default: fill_level = FILL_WIDTH'($urandom_range(EMPTY + 1, FULL - 1));
                endcase
            end
            tready        = ($urandom_range(0, 3) != 0);
            nfc_enable    = ($urandom_range(0, 15) != 0);
            rx_tvalid     = $urandom_range(0, 1) == 1;
            counter_reset = ($urandom_range(0, 99) == 0);
            rst_n         = ($urandom_range(0, 299) != 0);
            cycle();
        end

        rst_n = 1'b1; counter_reset = 1'b0; tready = 1'b1; nfc_enable = 1'b0;
        repeat (10) cycle();
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
